pid_relock_ctrl: RTL and testbench

- Supervisory sequencer for the PID relock sweep.
- Watches the error/monitor signal against a lock window.
- Drives the sweep generator's enable, the PID integrator hold, and an integrator-clear pulse.
- Bounds each search with a timeout and an attempt limit, latching a fault for the register bank.
- Sits between the register interface and one PID channel's relock sweep/PID pair.

---
 rtl/pid_relock_ctrl_pkg.sv | 21 ++
 rtl/pid_relock_ctrl_timer.sv | 32 +++
 rtl/pid_relock_ctrl.sv | 150 +++++++++++++++
 tb/tb_pid_relock_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pid_relock_ctrl_pkg.sv
// Shared state codes for the PID relock supervisor.
// Also reused by the register bank status decode.
package pid_relock_ctrl_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOCKED = 3'd1;
  localparam logic [2:0] ST_CLEAR  = 3'd2;
  localparam logic [2:0] ST_SEARCH = 3'd3;
  localparam logic [2:0] ST_SETTLE = 3'd4;
  localparam logic [2:0] ST_FAULT  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_LOCKED = ST_LOCKED,
    S_CLEAR  = ST_CLEAR,
    S_SEARCH = ST_SEARCH,
    S_SETTLE = ST_SETTLE,
    S_FAULT  = ST_FAULT
  } state_t;

endpackage

// File: rtl/pid_relock_ctrl_timer.sv
// relock_timer: clearable/loadable up-counter with hold.
// Ports: clr > load > en; hit = (count == cmp).
module relock_timer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] cmp,
  output logic         hit
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

  assign hit = (count == cmp);

endmodule

// File: rtl/pid_relock_ctrl.sv
// pid_relock_ctrl: relock supervisor for one PID channel.
// In: window/config/rails/ack. Out: sweep, hold, clear, status.
module pid_relock_ctrl
  import pid_relock_ctrl_pkg::*;
#(
  parameter int TIMEOUT_BITS = 32,
  parameter int SETTLE_BITS  = 24,
  parameter int ATT_BITS     = 8,
  parameter int CNT_BITS     = 16
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    enable_i,
  input  logic [11:0]             signal_i,
  input  logic [11:0]             min_val_i,
  input  logic [11:0]             max_val_i,
  input  logic [1:0]              railed_i,
  input  logic [TIMEOUT_BITS-1:0] timeout_i,
  input  logic [SETTLE_BITS-1:0]  settle_i,
  input  logic [ATT_BITS-1:0]     max_att_i,
  input  logic                    ack_i,
  output logic                    sweep_on_o,
  output logic                    pid_hold_o,
  output logic                    pid_clear_o,
  output logic [2:0]              state_o,
  output logic [ATT_BITS-1:0]     attempts_o,
  output logic [CNT_BITS-1:0]     lost_cnt_o,
  output logic                    fault_o
);

  state_t state, nxt;
  logic in_win, rail_q;
  logic [ATT_BITS-1:0] att, att_nxt;
  logic [CNT_BITS-1:0] lost, lost_nxt;
  logic srch_clr, srch_en, srch_hit;
  logic stl_clr, stl_en, stl_hit;

  relock_timer #(.W(TIMEOUT_BITS)) u_srch (
    .clk      (clk_i),
    .rst_n    (rstn_i),
    .clr      (srch_clr),
    .load     (1'b0),
    .load_val ('0),
    .en       (srch_en),
    .cmp      (timeout_i - TIMEOUT_BITS'(1)),
    .hit      (srch_hit)
  );

  relock_timer #(.W(SETTLE_BITS)) u_stl (
    .clk      (clk_i),
    .rst_n    (rstn_i),
    .clr      (stl_clr),
    .load     (1'b0),
    .load_val ('0),
    .en       (stl_en),
    .cmp      (settle_i),
    .hit      (stl_hit)
  );

  always_comb begin
    nxt      = state;
    att_nxt  = att;
    lost_nxt = lost;
    srch_clr = 1'b0;
    srch_en  = 1'b0;
    stl_clr  = 1'b1;
    stl_en   = 1'b0;
    if (!enable_i) begin
      nxt      = S_IDLE;
      att_nxt  = '0;
      srch_clr = 1'b1;
    end else begin
      unique case (state)
        S_IDLE: begin
          nxt = in_win ? S_LOCKED : S_CLEAR;
        end
        S_LOCKED: begin
          att_nxt = '0;
          if (!in_win) begin
            if (!(&lost)) lost_nxt = lost + CNT_BITS'(1);
            nxt = S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (!(&att)) att_nxt = att + ATT_BITS'(1);
          srch_clr = 1'b1;
          nxt      = S_SEARCH;
        end
        S_SEARCH: begin
          srch_en = 1'b1;
          if (in_win) begin
            nxt = S_SETTLE;
          end else if ((timeout_i != '0) && srch_hit) begin
            // attempts counts the CLEAR that started this search
            if ((max_att_i != '0) && (att >= max_att_i))
              nxt = S_FAULT;
            else
              nxt = S_CLEAR;
          end
        end
        S_SETTLE: begin
          // search timer is left frozen so a false lock
          // does not extend the attempt budget
          stl_clr = 1'b0;
          stl_en  = 1'b1;
          if (!in_win) begin
            nxt = S_SEARCH;
          end else if (stl_hit) begin
            nxt     = S_LOCKED;
            att_nxt = '0;
          end
        end
        S_FAULT: begin
          if (ack_i) begin
            att_nxt = '0;
            nxt     = S_CLEAR;
          end
        end
        default: nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state  <= S_IDLE;
      in_win <= 1'b0;
      rail_q <= 1'b0;
      att    <= '0;
      lost   <= '0;
    end else begin
      state  <= nxt;
      in_win <= (min_val_i < signal_i) && (signal_i < max_val_i);
      // rails as seen on the cycle that moves us into CLEAR
      rail_q <= |railed_i;
      att    <= att_nxt;
      lost   <= lost_nxt;
    end
  end

  assign sweep_on_o  = state inside {S_LOCKED, S_CLEAR,
                                     S_SEARCH, S_SETTLE};
  assign pid_hold_o  = state inside {S_CLEAR, S_SEARCH, S_FAULT};
  assign pid_clear_o = (state == S_CLEAR) && rail_q;
  assign fault_o     = (state == S_FAULT);
  assign state_o     = state;
  assign attempts_o  = att;
  assign lost_cnt_o  = lost;

endmodule

// File: tb/tb_pid_relock_ctrl.sv
// Self-checking bench for pid_relock_ctrl.
// Window table plus directed multi-cycle sequences.
module tb_pid_relock_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        enable;
  logic [11:0] signal, min_val, max_val;
  logic [1:0]  railed;
  logic [31:0] timeout;
  logic [23:0] settle;
  logic [7:0]  max_att;
  logic        ack;

  logic        sweep, hold, clr, fault;
  logic [2:0]  state;
  logic [7:0]  att;
  logic [15:0] lost;

  logic        s_sweep, s_hold, s_clr, s_fault;
  logic [2:0]  s_state;
  logic [7:0]  s_att;
  logic [3:0]  s_lost;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  pid_relock_ctrl dut (
    .clk_i(clk), .rstn_i(rstn), .enable_i(enable),
    .signal_i(signal), .min_val_i(min_val),
    .max_val_i(max_val), .railed_i(railed),
    .timeout_i(timeout), .settle_i(settle),
    .max_att_i(max_att), .ack_i(ack),
    .sweep_on_o(sweep), .pid_hold_o(hold),
    .pid_clear_o(clr), .state_o(state),
    .attempts_o(att), .lost_cnt_o(lost),
    .fault_o(fault)
  );

  pid_relock_ctrl #(.CNT_BITS(4)) u_sat (
    .clk_i(clk), .rstn_i(rstn), .enable_i(enable),
    .signal_i(signal), .min_val_i(min_val),
    .max_val_i(max_val), .railed_i(railed),
    .timeout_i(timeout), .settle_i(settle),
    .max_att_i(max_att), .ack_i(ack),
    .sweep_on_o(s_sweep), .pid_hold_o(s_hold),
    .pid_clear_o(s_clr), .state_o(s_state),
    .attempts_o(s_att), .lost_cnt_o(s_lost),
    .fault_o(s_fault)
  );

  typedef struct {
    logic [11:0] sig;
    logic [1:0]  rail;
    logic [2:0]  st;
    logic        sw;
    logic        hd;
    logic        cl;
  } vec_t;

  vec_t vt[8];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic chk_st(input string name,
                        input logic [2:0] st,
                        input logic [7:0] a);
    check({name, ".state"}, 32'(state), 32'(st));
    check({name, ".att"}, 32'(att), 32'(a));
  endtask

  initial begin
    vt[0] = '{12'd2000, 2'b11, 3'd1, 1'b1, 1'b0, 1'b0};
    vt[1] = '{12'd1000, 2'b01, 3'd2, 1'b1, 1'b1, 1'b1};
    vt[2] = '{12'd3000, 2'b10, 3'd2, 1'b1, 1'b1, 1'b1};
    vt[3] = '{12'd1001, 2'b00, 3'd1, 1'b1, 1'b0, 1'b0};
    vt[4] = '{12'd2999, 2'b01, 3'd1, 1'b1, 1'b0, 1'b0};
    vt[5] = '{12'd500,  2'b00, 3'd2, 1'b1, 1'b1, 1'b0};
    vt[6] = '{12'd4000, 2'b01, 3'd2, 1'b1, 1'b1, 1'b1};
    vt[7] = '{12'd999,  2'b10, 3'd2, 1'b1, 1'b1, 1'b1};

    rstn = 1'b0; enable = 1'b0; signal = 12'd2000;
    min_val = 12'd1000; max_val = 12'd3000;
    railed = 2'b00; timeout = 32'd0; settle = 24'd0;
    max_att = 8'd0; ack = 1'b0;

    #12;
    check("rst.state", 32'(state), 32'd0);
    check("rst.sweep", 32'(sweep), 32'd0);
    check("rst.hold", 32'(hold), 32'd0);
    check("rst.fault", 32'(fault), 32'd0);
    check("rst.lost", 32'(lost), 32'd0);
    rstn = 1'b1;

    // window table: from IDLE, one enable edge decides
    for (int i = 0; i < 8; i++) begin
      enable = 1'b0;
      signal = vt[i].sig;
      railed = vt[i].rail;
      tick(2);
      enable = 1'b1;
      tick(1);
      check($sformatf("win%0d.state", i),
            32'(state), 32'(vt[i].st));
      check($sformatf("win%0d.sweep", i),
            32'(sweep), 32'(vt[i].sw));
      check($sformatf("win%0d.hold", i),
            32'(hold), 32'(vt[i].hd));
      check($sformatf("win%0d.clr", i),
            32'(clr), 32'(vt[i].cl));
    end
    check("win.lost", 32'(lost), 32'd0);

    // lock, then loss with upper rail
    enable = 1'b0; signal = 12'd2000; railed = 2'b00;
    tick(2);
    enable = 1'b1;
    tick(1);
    chk_st("lock", 3'd1, 8'd0);
    check("lock.hold", 32'(hold), 32'd0);
    signal = 12'd500; railed = 2'b10;
    tick(1);
    check("loss.pending", 32'(state), 32'd1);
    tick(1);
    chk_st("loss.clear", 3'd2, 8'd0);
    check("loss.clr", 32'(clr), 32'd1);
    check("loss.lost", 32'(lost), 32'd1);
    railed = 2'b00;
    tick(1);
    chk_st("loss.search", 3'd3, 8'd1);
    check("loss.hold", 32'(hold), 32'd1);
    check("loss.clr0", 32'(clr), 32'd0);

    // timeouts with attempt limit 3
    timeout = 32'd100; max_att = 8'd3; railed = 2'b01;
    tick(99);
    chk_st("to1.pre", 3'd3, 8'd1);
    tick(1);
    chk_st("to1.clear", 3'd2, 8'd1);
    check("to1.clr", 32'(clr), 32'd1);
    tick(1);
    chk_st("to1.search", 3'd3, 8'd2);
    tick(100);
    chk_st("to2.clear", 3'd2, 8'd2);
    tick(1);
    chk_st("to2.search", 3'd3, 8'd3);
    tick(99);
    chk_st("to3.pre", 3'd3, 8'd3);
    tick(1);
    chk_st("fault", 3'd5, 8'd3);
    check("fault.fault", 32'(fault), 32'd1);
    check("fault.sweep", 32'(sweep), 32'd0);
    check("fault.hold", 32'(hold), 32'd1);
    tick(5);
    check("fault.held", 32'(state), 32'd5);
    ack = 1'b1;
    tick(1);
    chk_st("ack.clear", 3'd2, 8'd0);
    ack = 1'b0; max_att = 8'd0; railed = 2'b00;
    tick(1);
    chk_st("ack.search", 3'd3, 8'd1);

    // settle, drop out, timer resumes from frozen value
    settle = 24'd50;
    tick(10);
    signal = 12'd2000;
    tick(2);
    chk_st("stl1", 3'd4, 8'd1);
    check("stl1.hold", 32'(hold), 32'd0);
    tick(28);
    check("stl1.late", 32'(state), 32'd4);
    signal = 12'd500;
    tick(2);
    chk_st("stl1.back", 3'd3, 8'd1);
    tick(87);
    check("resume.pre", 32'(state), 32'd3);
    tick(1);
    check("resume.clear", 32'(state), 32'd2);
    tick(1);
    chk_st("resume.search", 3'd3, 8'd2);
    signal = 12'd2000;
    tick(2);
    chk_st("stl2", 3'd4, 8'd2);
    tick(50);
    check("stl2.late", 32'(state), 32'd4);
    tick(1);
    chk_st("relock", 3'd1, 8'd0);

    // async reset mid-search
    signal = 12'd500;
    tick(2);
    check("loss2.lost", 32'(lost), 32'd2);
    tick(1);
    check("loss2.search", 32'(state), 32'd3);
    #3 rstn = 1'b0;
    #1;
    check("arst.state", 32'(state), 32'd0);
    check("arst.sweep", 32'(sweep), 32'd0);
    check("arst.hold", 32'(hold), 32'd0);
    check("arst.att", 32'(att), 32'd0);
    check("arst.lost", 32'(lost), 32'd0);
    tick(3);
    enable = 1'b0;
    rstn = 1'b1;
    tick(1);
    check("arst.idle", 32'(state), 32'd0);

    // enable drop mid-settle
    signal = 12'd2000; enable = 1'b1;
    tick(3);
    chk_st("en.settle", 3'd4, 8'd1);
    tick(2);
    enable = 1'b0;
    tick(1);
    chk_st("en.idle", 3'd0, 8'd0);
    check("en.sweep", 32'(sweep), 32'd0);

    // lost counter saturation on 4-bit instance
    settle = 24'd0; timeout = 32'd0;
    enable = 1'b1;
    tick(1);
    check("sat.lock", 32'(state), 32'd1);
    for (int i = 0; i < 17; i++) begin
      signal = 12'd3000;
      tick(2);
      signal = 12'd1500;
      tick(3);
      check($sformatf("sat%0d.lost", i), 32'(s_lost),
            (i < 15) ? 32'(i + 1) : 32'd15);
    end
    check("sat.main", 32'(lost), 32'd17);
    check("sat.state", 32'(s_state), 32'd1);
    check("sat.sweep", 32'(s_sweep), 32'd1);
    check("sat.hold", 32'(s_hold), 32'd0);
    check("sat.clr", 32'(s_clr), 32'd0);
    check("sat.att", 32'(s_att), 32'd0);
    check("sat.fault", 32'(s_fault), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end

endmodule
